// File: rtl/connect4_pkg.sv
// Shared Connect Four definitions: board geometry, cell encodings, address packing and sequencer states.
package connect4_pkg;

  localparam int ROWS        = 6;
  localparam int COLS        = 7;
  localparam int BOARD_CELLS = ROWS * COLS;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    SCAN_A,
    SCAN_D,
    DROP,
    WRITE,
    CHECK,
    OVER
  } seq_state_t;

  // Board address layout is {row, col}, row 0 at the bottom.
  function automatic logic [5:0] pack_addr(input logic [2:0] row, input logic [2:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/drop_anim_counter.sv
// Drop-animation row counter: loads the top row, then counts down one row per enabled tick.
// Only present when DROP_ANIM_EN is defined.
`ifdef DROP_ANIM_EN
module drop_anim_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec_en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec_en) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule
`endif

// File: rtl/move_sequencer.sv
// Move sequencer: takes the mover's column, scans it bottom-up, writes the piece, runs the win check (DROP_ANIM_EN adds a tick-paced drop).
// Latency: accepted req to write is 2*row+3 cycles; renderer owns the board port only in IDLE/OVER and must hold rd_req otherwise.
module move_sequencer
  import connect4_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       req1,
  input  logic       req2,
  input  logic [2:0] col1,
  input  logic [2:0] col2,
  output logic [5:0] mem_addr,
  output logic       mem_we,
  output logic [1:0] mem_wdata,
  input  logic [1:0] mem_rdata,
  input  logic       rd_req,
  input  logic [5:0] rd_addr,
  output logic       rd_gnt,
  output logic       rd_valid,
  output logic       chk_start,
  output logic [2:0] chk_row,
  output logic [2:0] chk_col,
  input  logic       chk_done,
  input  logic       chk_win,
  output logic [1:0] current_player,
  output logic       move_done,
  output logic       col_full,
  output logic       game_over,
  output logic [1:0] winner,
  output logic       draw
`ifdef DROP_ANIM_EN
  ,
  input  logic       tick,
  output logic       anim_valid,
  output logic [2:0] anim_row
`endif
);

  localparam logic [2:0] ROW_TOP   = 3'(ROWS - 1);
  localparam logic [2:0] COL_LIM   = 3'(COLS);
  localparam logic [5:0] CELLS_LIM = 6'(BOARD_CELLS);

  seq_state_t state_q, state_d;
  logic [2:0] row_q, row_d;
  logic [2:0] col_q, col_d;
  logic [1:0] player_q, player_d;
  logic [1:0] winner_q, winner_d;
  logic [5:0] move_cnt_q, move_cnt_d;
  logic       game_over_q, game_over_d;
  logic       draw_q, draw_d;
  logic       chk_start_q, chk_start_d;
  logic       rd_valid_q, rd_valid_d;
  logic       req_own;
  logic [2:0] col_own;

`ifdef DROP_ANIM_EN
  logic       anim_load;
  logic [2:0] anim_cnt;

  drop_anim_counter #(.W(3)) u_drop_anim (
    .clk      (clk),
    .reset    (reset),
    .load     (anim_load),
    .load_val (ROW_TOP),
    .dec_en   (tick && (state_q == DROP) && (anim_cnt != row_q)),
    .cnt      (anim_cnt)
  );

  assign anim_valid = (state_q == DROP);
  assign anim_row   = anim_cnt;
`endif

  // Only the player whose turn it is can be heard.
  assign req_own = (player_q == CELL_P1) ? req1 : req2;
  assign col_own = (player_q == CELL_P1) ? col1 : col2;

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    player_d    = player_q;
    winner_d    = winner_q;
    move_cnt_d  = move_cnt_q;
    game_over_d = game_over_q;
    draw_d      = draw_q;
    mem_we      = 1'b0;
    mem_wdata   = player_q;
    move_done   = 1'b0;
    col_full    = 1'b0;
    rd_gnt      = 1'b0;
    mem_addr    = pack_addr(row_q, col_q);
`ifdef DROP_ANIM_EN
    anim_load   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (req_own && (col_own < COL_LIM)) begin
          col_d   = col_own;
          row_d   = 3'd0;
          state_d = SCAN_A;
        end else begin
          col_full = req_own;
          rd_gnt   = rd_req;
        end
      end
      SCAN_A: state_d = SCAN_D;
      SCAN_D: begin
        if (mem_rdata == CELL_EMPTY) begin
`ifdef DROP_ANIM_EN
          anim_load = 1'b1;
          state_d   = DROP;
`else
          state_d   = WRITE;
`endif
        end else if (row_q == ROW_TOP) begin
          col_full = 1'b1;
          state_d  = IDLE;
        end else begin
          row_d   = row_q + 3'd1;
          state_d = SCAN_A;
        end
      end
`ifdef DROP_ANIM_EN
      DROP: begin
        if (anim_cnt == row_q) begin
          state_d = WRITE;
        end
      end
`endif
      WRITE: begin
        mem_we     = 1'b1;
        move_done  = 1'b1;
        move_cnt_d = move_cnt_q + 6'd1;
        state_d    = CHECK;
      end
      CHECK: begin
        if (chk_done) begin
          if (chk_win) begin
            winner_d    = player_q;
            game_over_d = 1'b1;
            state_d     = OVER;
          end else if (move_cnt_q == CELLS_LIM) begin
            draw_d      = 1'b1;
            game_over_d = 1'b1;
            state_d     = OVER;
          end else begin
            player_d = (player_q == CELL_P1) ? CELL_P2 : CELL_P1;
            state_d  = IDLE;
          end
        end
      end
      OVER:    rd_gnt  = rd_req;
      default: state_d = IDLE;
    endcase

    if (rd_gnt) begin
      mem_addr = rd_addr;
    end
  end

  assign chk_start_d = (state_q == WRITE);
  assign rd_valid_d  = rd_gnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      row_q       <= 3'd0;
      col_q       <= 3'd0;
      player_q    <= CELL_P1;
      winner_q    <= CELL_EMPTY;
      move_cnt_q  <= 6'd0;
      game_over_q <= 1'b0;
      draw_q      <= 1'b0;
      chk_start_q <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      player_q    <= player_d;
      winner_q    <= winner_d;
      move_cnt_q  <= move_cnt_d;
      game_over_q <= game_over_d;
      draw_q      <= draw_d;
      chk_start_q <= chk_start_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign chk_start      = chk_start_q;
  assign chk_row        = row_q;
  assign chk_col        = col_q;
  assign current_player = player_q;
  assign game_over      = game_over_q;
  assign winner         = winner_q;
  assign draw           = draw_q;
  assign rd_valid       = rd_valid_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer: board RAM model plus a board-level reference of Connect Four moves.
module tb_move_sequencer;
  import connect4_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       req1, req2;
  logic [2:0] col1, col2;
  logic [5:0] mem_addr;
  logic       mem_we;
  logic [1:0] mem_wdata;
  logic [1:0] mem_rdata;
  logic       rd_req;
  logic [5:0] rd_addr;
  logic       rd_gnt, rd_valid;
  logic       chk_start;
  logic [2:0] chk_row, chk_col;
  logic       chk_done, chk_win;
  logic [1:0] current_player;
  logic       move_done, col_full, game_over, draw;
  logic [1:0] winner;

  move_sequencer dut (
    .clk(clk), .reset(reset), .req1(req1), .req2(req2), .col1(col1), .col2(col2),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid),
    .chk_start(chk_start), .chk_row(chk_row), .chk_col(chk_col),
    .chk_done(chk_done), .chk_win(chk_win), .current_player(current_player),
    .move_done(move_done), .col_full(col_full), .game_over(game_over),
    .winner(winner), .draw(draw)
  );

  always #5 clk = ~clk;

  // Board RAM: synchronous read, data one cycle after the address.
  logic [1:0] ram [64];
  logic       clr_ram = 1'b0;
  int         wr_count = 0;

  always @(posedge clk) begin
    if (clr_ram) begin
      for (int i = 0; i < 64; i++) ram[i] <= 2'b00;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    if (mem_we) wr_count <= wr_count + 1;
    mem_rdata <= ram[mem_addr];
  end

  // Reference model: the game as a grid of cells.
  int mb [ROWS][COLS];
  int m_cur, m_moves, m_over, m_winner, m_draw;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int first_empty(input int c);
    for (int r = 0; r < ROWS; r++) if (mb[r][c] == 0) return r;
    return -1;
  endfunction

  task automatic model_reset(input bit clear_board);
    m_cur = 1; m_moves = 0; m_over = 0; m_winner = 0; m_draw = 0;
    if (clear_board)
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) mb[r][c] = 0;
  endtask

  task automatic reset_and_clear();
    @(negedge clk);
    reset = 1'b1; clr_ram = 1'b1;
    req1 = 0; req2 = 0; rd_req = 0; chk_done = 0; chk_win = 0;
    @(negedge clk);
    clr_ram = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset(1);
  endtask

  // who: 1 = req1, 2 = req2, 3 = both. col is the column the mover picks.
  task automatic play(input int who, input int col, input bit win, input bit hold_rd);
    bit accepted, activity, gnt_bad, gnt_ok;
    int exp_row, k, w0, other, extra;
    accepted = (m_over == 0) && ((who == 3) || (who == m_cur));
    other    = (col + 3) % COLS;
    w0       = wr_count;
    activity = 0; gnt_bad = 0;
    @(negedge clk);
    req1    = (who & 1) != 0;
    req2    = (who & 2) != 0;
    col1    = 3'((m_cur == 1) ? col : other);
    col2    = 3'((m_cur == 2) ? col : other);
    rd_req  = hold_rd;
    rd_addr = 6'($urandom_range(0, 63));
    #1;
    if (!accepted) begin
      if (move_done || col_full) activity = 1;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (i == 0) begin req1 = 0; req2 = 0; end
        #1;
        if (move_done || col_full || mem_we) activity = 1;
        if (rd_gnt !== rd_req) gnt_bad = 1;
      end
      check("ignored_activity", activity, 0);
      check("ignored_player", current_player, m_cur);
      check("ignored_gnt", gnt_bad, 0);
      check("ignored_writes", wr_count, w0);
      rd_req = 0;
      return;
    end
    if (col >= COLS) begin
      check("badcol_full", col_full, 1);
      @(negedge clk);
      req1 = 0; req2 = 0;
      #1;
      check("badcol_player", current_player, m_cur);
      check("badcol_writes", wr_count, w0);
      rd_req = 0;
      return;
    end
    if (hold_rd) check("accept_gnt", rd_gnt, 0);
    exp_row = first_empty(col);
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin req1 = 0; req2 = 0; end
      #1;
      if (rd_gnt) gnt_bad = 1;
      if (move_done || col_full) break;
    end
    if (exp_row < 0) begin
      check("full_pulse", col_full, 1);
      check("full_cycles", k, 12);
      @(negedge clk); #1;
      check("full_writes", wr_count, w0);
      check("full_player", current_player, m_cur);
      check("full_gnt_after", rd_gnt, hold_rd);
      check("full_gnt_block", gnt_bad, 0);
      rd_req = 0;
      return;
    end
    check("move_done", move_done, 1);
    check("move_latency", k, 2 * exp_row + 3);
    check("mem_we", mem_we, 1);
    check("mem_addr", mem_addr, exp_row * 8 + col);
    check("mem_wdata", mem_wdata, m_cur);
    mb[exp_row][col] = m_cur;
    m_moves++;
    @(negedge clk); #1;
    check("chk_start", chk_start, 1);
    check("chk_row", chk_row, exp_row);
    check("chk_col", chk_col, col);
    if (rd_gnt) gnt_bad = 1;
    extra = $urandom_range(0, 2);
    for (int i = 0; i < extra; i++) begin
      @(negedge clk); #1;
      if (rd_gnt || chk_start) gnt_bad = 1;
    end
    chk_done = 1; chk_win = win;
    @(negedge clk);
    chk_done = 0; chk_win = 0;
    #1;
    if (win) begin m_over = 1; m_winner = m_cur; end
    else if (m_moves == BOARD_CELLS) begin m_over = 1; m_draw = 1; end
    else m_cur = 3 - m_cur;
    check("player", current_player, m_cur);
    check("game_over", game_over, m_over);
    check("winner", winner, m_winner);
    check("draw", draw, m_draw);
    check("gnt_blocked", gnt_bad, 0);
    check("gnt_after", rd_gnt, hold_rd);
    gnt_ok = hold_rd ? (mem_addr == rd_addr) : 1'b1;
    check("gnt_addr", gnt_ok, 1);
    @(negedge clk); #1;
    check("rd_valid", rd_valid, hold_rd);
    check("writes", wr_count, w0 + 1);
    rd_req = 0;
  endtask

  function automatic int pick_col();
    int c;
    for (int t = 0; t < 50; t++) begin
      c = $urandom_range(0, COLS - 1);
      if (first_empty(c) >= 0) return c;
    end
    for (int i = 0; i < COLS; i++) if (first_empty(i) >= 0) return i;
    return 0;
  endfunction

  initial begin
    int w0;
    reset = 1; req1 = 0; req2 = 0; col1 = 0; col2 = 0;
    rd_req = 0; rd_addr = 0; chk_done = 0; chk_win = 0;
    model_reset(1);
    #1;
    check("rst_player", current_player, 1);
    check("rst_game_over", game_over, 0);
    check("rst_winner", winner, 0);
    check("rst_draw", draw, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_pulses", {move_done, col_full, chk_start, rd_gnt, rd_valid}, 0);
    reset_and_clear();

    play(1, 3, 0, 1);                    // P1 into an empty column
    play(1, 0, 0, 0);                    // P1 out of turn
    play(2, 4, 0, 0);                    // P2 moves
    play(2, 1, 0, 0);                    // P2 out of turn
    play(3, 5, 0, 1);                    // both request: P1 wins the slot
    play(2, 7, 0, 0);                    // column out of range
    for (int i = 0; i < ROWS; i++) play(m_cur, 2, 0, 1'($urandom_range(0, 1)));
    play(m_cur, 2, 0, 1);                // column 2 full

    // chk_done outside CHECK has no effect
    @(negedge clk);
    chk_done = 1; chk_win = 1;
    @(negedge clk);
    chk_done = 0; chk_win = 0;
    #1;
    check("stray_done_over", game_over, 0);
    check("stray_done_winner", winner, 0);
    check("stray_done_player", current_player, m_cur);

    // reset while scanning
    w0 = wr_count;
    @(negedge clk);
    if (m_cur == 1) begin req1 = 1; col1 = 3'd6; end else begin req2 = 1; col2 = 3'd6; end
    @(negedge clk);
    req1 = 0; req2 = 0;
    @(negedge clk);
    reset = 1;
    #1;
    check("midrst_player", current_player, 1);
    check("midrst_we", mem_we, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    rd_req = 1;
    #1;
    check("midrst_writes", wr_count, w0);
    check("midrst_idle_gnt", rd_gnt, 1);
    rd_req = 0;

    // full game ending in a draw
    reset_and_clear();
    for (int i = 0; i < BOARD_CELLS; i++) play(m_cur, pick_col(), 0, 1'($urandom_range(0, 1)));
    check("draw_flag", draw, 1);
    play(m_cur, pick_col(), 0, 1);
    play(3, 0, 0, 0);

    // P2 wins on its second move
    reset_and_clear();
    for (int i = 0; i < 3; i++) play(m_cur, pick_col(), 0, 1'($urandom_range(0, 1)));
    play(2, pick_col(), 1, 1);
    check("p2_winner", winner, 2);
    play(1, pick_col(), 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/move_sequencer.md
# move_sequencer

Sequences every move into the shared single-port board memory and arbitrates that port between the two player inputs and the display renderer. It accepts a column from the player whose turn it is and scans that column bottom-up for the first empty cell. It writes the player's piece, then hands off to the win checker and advances the turn. It sits between the debounced player inputs, the board RAM, the win-check logic and the VGA renderer.

## Interface
- ROWS, 6, board rows; row 0 is the bottom row.
- COLS, 7, board columns; valid column values are 0..COLS-1.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- req1 / req2  in  1  single-cycle move requests from player 1 / player 2.
- col1 / col2  in  3  column selected by player 1 / player 2.
- mem_addr  out  6  board address {row[2:0], col[2:0]}.
- mem_we  out  1  board write enable.
- mem_wdata  out  2  cell value to write.
- mem_rdata  in  2  read data, valid one cycle after mem_addr.
- rd_req  in  1  renderer read request.
- rd_addr  in  6  renderer address.
- rd_gnt  out  1  renderer owns the port this cycle.
- rd_valid  out  1  mem_rdata is the renderer's data (rd_gnt delayed by 1 cycle).
- chk_start  out  1  one-cycle pulse: start win check at chk_row/chk_col.
- chk_row  out  3  row of the last placed piece.
- chk_col  out  3  column of the last placed piece.
- chk_done  in  1  win checker finished.
- chk_win  in  1  qualifies chk_done.
- current_player  out  2  01 = P1, 10 = P2.
- move_done  out  1  one-cycle pulse when a piece is written.
- col_full  out  1  one-cycle pulse when a move is rejected.
- game_over  out  1  sticky.
- winner  out  2  00 = none/draw, 01 = P1, 10 = P2.
- draw  out  1  sticky; set when the board fills with no win.

## Operation
- Cell encoding: 00 empty, 01 P1, 10 P2.
- States: IDLE, SCAN_A, SCAN_D, DROP (DROP_ANIM_EN only), WRITE, CHECK, OVER.
- IDLE
  - Only the current player's req is honoured; the other player's req is ignored, including when both arrive in the same cycle.
  - On an accepted req: latch the column, set row counter = 0, go to SCAN_A.
  - A column ≥ COLS: pulse col_full, stay in IDLE, player unchanged.
- SCAN_A: drive mem_addr = {row, col}; go to SCAN_D.
- SCAN_D: sample mem_rdata.
  - Empty: latch row; go to DROP or WRITE.
  - Occupied and row < ROWS-1: row+1, go to SCAN_A.
  - Occupied and row == ROWS-1: pulse col_full, return to IDLE, player unchanged.
- WRITE
  - mem_we = 1, mem_wdata = current_player.
  - Pulse move_done; increment the 6-bit move counter.
  - Go to CHECK and pulse chk_start on entry.
- CHECK: wait for chk_done.
  - chk_win: winner = current_player, game_over = 1, go to OVER.
  - Otherwise, move counter == ROWS*COLS (42): draw = 1, game_over = 1, go to OVER.
  - Otherwise: toggle current_player, go to IDLE.
- OVER: absorbing; all reqs ignored until reset.
- Port arbitration
  - rd_gnt = rd_req while in IDLE or OVER, except in the cycle an IDLE move is accepted (the move wins).
  - In every other state, rd_gnt = 0 and the renderer must hold its request.
  - mem_addr = rd_addr whenever rd_gnt = 1.
- Reset mid-move aborts the move with no write; the board RAM contents are not cleared by this block.

## Timing
- Reset values: current_player = 01, game_over = 0, winner = 00, draw = 0; all pulses, mem_we, rd_gnt and rd_valid = 0; state IDLE.
- Scan costs 2 cycles per row inspected.
- Accepted req to move_done, empty bottom row, no animation: 3 cycles (SCAN_A, SCAN_D, WRITE); worst case (row 5) 13 cycles.
- chk_start fires in the cycle after WRITE.
- chk_done may arrive at any latency ≥ 1 cycle; a chk_done outside CHECK is ignored.
- rd_valid asserts exactly 1 cycle after rd_gnt.

## Configuration
- DROP_ANIM_EN defined
  - Adds input tick (1 bit) and outputs anim_valid (1 bit) and anim_row (3 bits).
  - DROP starts at anim_row = ROWS-1 and decrements on each tick until it reaches the target row, then goes to WRITE; anim_valid is high throughout DROP.
  - The renderer stays blocked during DROP.
- DROP_ANIM_EN undefined: no DROP state and no extra ports; SCAN_D goes directly to WRITE.

## Structure
- Shared package connect4_pkg
  - Cell encodings CELL_EMPTY / CELL_P1 / CELL_P2.
  - ROWS, COLS, BOARD_CELLS = 42.
  - Address-pack function {row, col}.
  - State enum for this block.
- Sub-module drop_anim_counter: down-counter with a tick enable, instantiated only under DROP_ANIM_EN.

## Test plan
- Empty board, P1 req1 with col1 = 3 → write at addr {0,3} with data 01 three cycles later, move_done pulse, chk_start with chk_row = 0 / chk_col = 3; chk_done = 1, chk_win = 0 → current_player = 10.
- Column 2 pre-filled to rows 0..5, req with col = 2 → 12 scan cycles, col_full pulse, no mem_we, player unchanged.
- req2 while current_player = 01, and req1 + req2 in the same cycle → only req1 accepted; req2 ignored.
- rd_req held during a move → rd_gnt = 0 from SCAN_A through CHECK; granted the first IDLE cycle after; rd_valid follows 1 cycle later.
- 42 alternating non-winning moves → draw = 1, game_over = 1, winner = 00; further reqs ignored. Separately, chk_win = 1 on P2's move → winner = 10.
- Reset asserted during SCAN_D → no write, current_player = 01, state IDLE; with DROP_ANIM_EN, target row 0 needs 5 ticks before WRITE.
